// File: rtl/dvp_pkg.sv
// Shared types and sizing helpers for the DVP capture engine.
// The default pixel layout (8-bit bus, 2 beats/pixel) is exported for downstream writers.
package dvp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    WAIT_FRAME,
    ACTIVE
  } state_t;

  localparam int DEF_DATA_W        = 8;
  localparam int DEF_BYTES_PER_PIX = 2;
  localparam int DEF_MAX_COLS      = 640;
  localparam int DEF_MAX_ROWS      = 480;
  localparam int PIX_W             = DEF_DATA_W * DEF_BYTES_PER_PIX;
  localparam int COL_W             = $clog2(DEF_MAX_COLS);
  localparam int ROW_W             = $clog2(DEF_MAX_ROWS);

  typedef struct packed {
    logic             sof;
    logic             eol;
    logic [PIX_W-1:0] data;
  } fifo_entry_t;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dvp_pixel_fifo.sv
// Show-ahead synchronous FIFO: rd_data always presents the oldest entry while !empty.
// Writes are refused when full; full reflects the occupancy before any same-cycle pop.
module dvp_pixel_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [W-1:0] wr_data,
  input  logic         rd,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count;
  logic          wr_en, rd_en;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign wr_en   = wr & ~full;
  assign rd_en   = rd & ~empty;
  assign rd_data = mem[rp];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr_en) wp <= wp + AW'(1);
      if (rd_en) rp <= rp + AW'(1);
      count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
    end
  end

endmodule

// File: rtl/dvp_capture.sv
// DVP camera capture: XCLK generation, oversampled sensor interface, pixel assembly, output FIFO.
// Define DVP_DECIMATE_EN to keep only even columns of even rows (2x2 decimation).
module dvp_capture
  import dvp_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int BYTES_PER_PIX = DEF_BYTES_PER_PIX,
  parameter int MAX_COLS      = DEF_MAX_COLS,
  parameter int MAX_ROWS      = DEF_MAX_ROWS,
  parameter int FIFO_DEPTH    = 16,
  parameter int XCLK_DIV      = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cam_pclk,
  input  logic                            cam_vsync,
  input  logic                            cam_href,
  input  logic [DATA_W-1:0]               cam_data,
  output logic                            cam_xclk,
  input  logic                            enable,
  output logic                            pix_valid,
  input  logic                            pix_ready,
  output logic [BYTES_PER_PIX*DATA_W-1:0] pix_data,
  output logic                            pix_sof,
  output logic                            pix_eol,
  output logic [15:0]                     frame_cnt,
  output logic                            overflow,
  input  logic                            clr_overflow,
  output logic                            busy
);

  localparam int PW = BYTES_PER_PIX * DATA_W;
  localparam int CW = cnt_w(MAX_COLS);
  localparam int RW = cnt_w(MAX_ROWS);
  localparam int BW = cnt_w(BYTES_PER_PIX);
  localparam int XW = cnt_w(XCLK_DIV / 2);

  typedef struct packed {
    logic          sof;
    logic          eol;
    logic [PW-1:0] data;
  } entry_t;

  state_t state, next_state;
  logic [XW-1:0] xdiv;
  logic [1:0] pclk_sync, vs_sync, href_sync;
  logic [DATA_W-1:0] data_s1, data_s2, sdata;
  logic pclk_prev, stb, href_d1, href_d2, vs_d1, vs_d2;
  logic vs_rise, vs_fall, href_fall, frame_start, frame_end;
  logic [BW-1:0] beat;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [PW-1:0] shreg, pix_next, la_data;
  logic la_valid, sof_pending, sample_beat, beat_last, pix_done, keep;
  logic push_req, push_eol, wr_ok, drop, fifo_full, fifo_empty;
  entry_t wr_entry, rd_entry;

  // XCLK toggles every XCLK_DIV/2 cycles for an exact 50% duty cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xdiv     <= '0;
      cam_xclk <= 1'b0;
    end else if (xdiv == XW'(XCLK_DIV / 2 - 1)) begin
      xdiv     <= '0;
      cam_xclk <= ~cam_xclk;
    end else begin
      xdiv <= xdiv + XW'(1);
    end
  end

  // Sample strobe, data and href all come from the same synchronised stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pclk_sync <= '0;
      vs_sync   <= '0;
      href_sync <= '0;
      data_s1   <= '0;
      data_s2   <= '0;
      pclk_prev <= 1'b0;
      stb       <= 1'b0;
      sdata     <= '0;
      href_d1   <= 1'b0;
      href_d2   <= 1'b0;
      vs_d1     <= 1'b0;
      vs_d2     <= 1'b0;
    end else begin
      pclk_sync <= {pclk_sync[0], cam_pclk};
      vs_sync   <= {vs_sync[0], cam_vsync};
      href_sync <= {href_sync[0], cam_href};
      data_s1   <= cam_data;
      data_s2   <= data_s1;
      pclk_prev <= pclk_sync[1];
      stb       <= pclk_sync[1] & ~pclk_prev;
      sdata     <= data_s2;
      href_d1   <= href_sync[1];
      href_d2   <= href_d1;
      vs_d1     <= vs_sync[1];
      vs_d2     <= vs_d1;
    end
  end

  assign vs_rise     = vs_d1 & ~vs_d2;
  assign vs_fall     = ~vs_d1 & vs_d2;
  assign href_fall   = href_d2 & ~href_d1;
  assign frame_start = (state == WAIT_FRAME) & vs_fall;
  assign frame_end   = (state == ACTIVE) & vs_rise;
  assign busy        = (state == ACTIVE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (enable)  next_state = WAIT_VS;
      WAIT_VS:    if (vs_rise) next_state = WAIT_FRAME;
      WAIT_FRAME: if (vs_fall) next_state = ACTIVE;
      ACTIVE:     if (vs_rise) next_state = enable ? WAIT_FRAME : IDLE;
      default:    next_state = IDLE;
    endcase
  end

  assign sample_beat = stb & href_d1;
  assign beat_last   = (beat == BW'(BYTES_PER_PIX - 1));
  assign pix_done    = sample_beat & beat_last;
  assign pix_next    = (shreg << DATA_W) | PW'(sdata);

`ifdef DVP_DECIMATE_EN
  assign keep = ~col[0] & ~row[0];
`else
  assign keep = 1'b1;
`endif

  // The last kept pixel waits in a lookahead slot so href falling can tag it as end-of-line.
  always_comb begin
    push_req = 1'b0;
    push_eol = 1'b0;
    if (state == ACTIVE && la_valid) begin
      if (href_fall) begin
        push_req = 1'b1;
        push_eol = 1'b1;
      end else if (pix_done && keep) begin
        push_req = 1'b1;
      end
    end
    wr_entry = '{sof: sof_pending, eol: push_eol, data: la_data};
  end

  assign wr_ok = push_req & ~fifo_full;
  assign drop  = push_req & fifo_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat        <= '0;
      col         <= '0;
      row         <= '0;
      shreg       <= '0;
      la_valid    <= 1'b0;
      la_data     <= '0;
      sof_pending <= 1'b0;
    end else if (frame_start) begin
      beat        <= '0;
      col         <= '0;
      row         <= '0;
      la_valid    <= 1'b0;
      sof_pending <= 1'b1;
    end else if (state == ACTIVE) begin
      if (sample_beat) begin
        shreg <= pix_next;
        if (beat_last) begin
          beat <= '0;
          if (col != CW'(MAX_COLS - 1)) col <= col + CW'(1);
          if (keep) begin
            la_valid <= 1'b1;
            la_data  <= pix_next;
          end
        end else begin
          beat <= beat + BW'(1);
        end
      end
      // A partial pixel left when href drops is simply abandoned.
      if (href_fall) begin
        beat     <= '0;
        col      <= '0;
        la_valid <= 1'b0;
        if (row != RW'(MAX_ROWS - 1)) row <= row + RW'(1);
      end
      if (wr_ok) sof_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
      if (frame_end) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  dvp_pixel_fifo #(
    .W     (PW + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr_ok),
    .wr_data (wr_entry),
    .rd      (pix_ready),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign pix_valid = ~fifo_empty;
  assign pix_data  = rd_entry.data;
  assign pix_sof   = pix_valid & rd_entry.sof;
  assign pix_eol   = pix_valid & rd_entry.eol;

endmodule
